book_top_builder: RTL and testbench

- Maintains a small sorted depth-of-book per side from incremental price-level updates.
- Drives the best bid/ask quantity and `valid_book` inputs consumed by the microstructure feature engine.
- Sits between the market-data decoder and the feature engine.
- Accepts one level update at a time over a valid/ready handshake and publishes registered top-of-book after each update.

---
 rtl/book_top_builder.sv | 231 +++++++++++++++++++++++
 tb/tb_book_top_builder.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/book_top_builder.sv
// book_top_builder
//   Keeps a small sorted depth-of-book per side (bids descending, asks
//   ascending) from incremental price-level updates and publishes a
//   registered top-of-book after every accepted update.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   upd_valid/ready one-update handshake (one update per 3 cycles)
//   upd_side        0=bid, 1=ask
//   upd_price/qty   level price and new qty (qty 0 deletes the level)
//   upd_clear       clear both sides; side/price/qty ignored
//   best_bid_*      top bid price/qty (0 when the side is empty)
//   best_ask_*      top ask price/qty (0 when the side is empty)
//   valid_book      one-cycle strobe: new top-of-book, both sides non-empty
//   book_crossed    best bid >= best ask with both sides non-empty
//   drop_cnt        saturating count of inserts discarded on a full side
module book_top_builder #(
    parameter int DEPTH   = 4,
    parameter int PRICE_W = 32,
    parameter int QTY_W   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic               upd_side,
    input  logic [PRICE_W-1:0] upd_price,
    input  logic [QTY_W-1:0]   upd_qty,
    input  logic               upd_clear,
    output logic [PRICE_W-1:0] best_bid_px,
    output logic [QTY_W-1:0]   best_bid_qty,
    output logic [PRICE_W-1:0] best_ask_px,
    output logic [QTY_W-1:0]   best_ask_qty,
    output logic               valid_book,
    output logic               book_crossed,
    output logic [15:0]        drop_cnt
);

    typedef enum logic [1:0] {IDLE, APPLY, EMIT} state_t;

    state_t state, state_nxt;

    logic               lat_side;
    logic [PRICE_W-1:0] lat_price;
    logic [QTY_W-1:0]   lat_qty;
    logic               lat_clear;

    logic               bid_vld [DEPTH];
    logic [PRICE_W-1:0] bid_px  [DEPTH];
    logic [QTY_W-1:0]   bid_qty [DEPTH];
    logic               ask_vld [DEPTH];
    logic [PRICE_W-1:0] ask_px  [DEPTH];
    logic [QTY_W-1:0]   ask_qty [DEPTH];

    logic               cur_vld [DEPTH];
    logic [PRICE_W-1:0] cur_px  [DEPTH];
    logic [QTY_W-1:0]   cur_qty [DEPTH];
    logic               nxt_vld [DEPTH];
    logic [PRICE_W-1:0] nxt_px  [DEPTH];
    logic [QTY_W-1:0]   nxt_qty [DEPTH];

    logic match_found, ins_found, drop_inc;
    int   match_idx, ins_idx;

    // Ready is forced low while reset is held so no transfer can be seen
    // during reset; it comes back the moment reset releases.
    assign upd_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (upd_valid && upd_ready) state_nxt = APPLY;
            APPLY:   state_nxt = EMIT;
            EMIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_side  <= 1'b0;
            lat_price <= '0;
            lat_qty   <= '0;
            lat_clear <= 1'b0;
        end else if (state == IDLE && upd_valid && upd_ready) begin
            lat_side  <= upd_side;
            lat_price <= upd_price;
            lat_qty   <= upd_qty;
            lat_clear <= upd_clear;
        end
    end

    // View of the side selected by the latched update.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cur_vld[i] = lat_side ? ask_vld[i] : bid_vld[i];
            cur_px[i]  = lat_side ? ask_px[i]  : bid_px[i];
            cur_qty[i] = lat_side ? ask_qty[i] : bid_qty[i];
        end
    end

    // Next contents of the selected side. The insert position is the first
    // empty slot or the first slot the new price beats; on a full side with
    // no such slot the insert is dropped. Shifting down on insert naturally
    // pushes the worst level out of the last slot.
    always_comb begin
        match_found = 1'b0;
        match_idx   = 0;
        ins_found   = 1'b0;
        ins_idx     = 0;
        drop_inc    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            nxt_vld[i] = cur_vld[i];
            nxt_px[i]  = cur_px[i];
            nxt_qty[i] = cur_qty[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (!match_found && cur_vld[i] && cur_px[i] == lat_price) begin
                match_found = 1'b1;
                match_idx   = i;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (!ins_found && (!cur_vld[i] ||
                (lat_side ? (lat_price < cur_px[i]) : (lat_price > cur_px[i])))) begin
                ins_found = 1'b1;
                ins_idx   = i;
            end
        end

        if (match_found) begin
            if (lat_qty != '0) begin
                for (int i = 0; i < DEPTH; i++)
                    if (i == match_idx) nxt_qty[i] = lat_qty;
            end else begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (i >= match_idx) begin
                        nxt_vld[i] = cur_vld[i+1];
                        nxt_px[i]  = cur_px[i+1];
                        nxt_qty[i] = cur_qty[i+1];
                    end
                end
                nxt_vld[DEPTH-1] = 1'b0;
                nxt_px[DEPTH-1]  = '0;
                nxt_qty[DEPTH-1] = '0;
            end
        end else if (lat_qty != '0) begin
            if (ins_found) begin
                for (int i = 1; i < DEPTH; i++) begin
                    if (i > ins_idx) begin
                        nxt_vld[i] = cur_vld[i-1];
                        nxt_px[i]  = cur_px[i-1];
                        nxt_qty[i] = cur_qty[i-1];
                    end
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == ins_idx) begin
                        nxt_vld[i] = 1'b1;
                        nxt_px[i]  = lat_price;
                        nxt_qty[i] = lat_qty;
                    end
                end
            end else begin
                drop_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bid_vld[i] <= 1'b0;
                bid_px[i]  <= '0;
                bid_qty[i] <= '0;
                ask_vld[i] <= 1'b0;
                ask_px[i]  <= '0;
                ask_qty[i] <= '0;
            end
            drop_cnt <= '0;
        end else if (state == APPLY) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (lat_clear) begin
                    bid_vld[i] <= 1'b0;
                    bid_px[i]  <= '0;
                    bid_qty[i] <= '0;
                    ask_vld[i] <= 1'b0;
                    ask_px[i]  <= '0;
                    ask_qty[i] <= '0;
                end else if (lat_side) begin
                    ask_vld[i] <= nxt_vld[i];
                    ask_px[i]  <= nxt_px[i];
                    ask_qty[i] <= nxt_qty[i];
                end else begin
                    bid_vld[i] <= nxt_vld[i];
                    bid_px[i]  <= nxt_px[i];
                    bid_qty[i] <= nxt_qty[i];
                end
            end
            if (!lat_clear && drop_inc && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Top-of-book is refreshed on every EMIT; valid_book is cleared in
    // every other state so it is a single-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_bid_px  <= '0;
            best_bid_qty <= '0;
            best_ask_px  <= '0;
            best_ask_qty <= '0;
            valid_book   <= 1'b0;
            book_crossed <= 1'b0;
        end else if (state == EMIT) begin
            best_bid_px  <= bid_vld[0] ? bid_px[0]  : '0;
            best_bid_qty <= bid_vld[0] ? bid_qty[0] : '0;
            best_ask_px  <= ask_vld[0] ? ask_px[0]  : '0;
            best_ask_qty <= ask_vld[0] ? ask_qty[0] : '0;
            valid_book   <= bid_vld[0] && ask_vld[0];
            book_crossed <= bid_vld[0] && ask_vld[0] && (bid_px[0] >= ask_px[0]);
        end else begin
            valid_book   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_book_top_builder.sv
// tb_book_top_builder
//   Drives level updates into book_top_builder, keeps a queue-based model of
//   both book sides, and scores each EMIT against expectations queued when
//   the update was transferred.
module tb_book_top_builder;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        upd_valid;
    logic        upd_ready;
    logic        upd_side;
    logic [31:0] upd_price;
    logic [63:0] upd_qty;
    logic        upd_clear;
    logic [31:0] best_bid_px;
    logic [63:0] best_bid_qty;
    logic [31:0] best_ask_px;
    logic [63:0] best_ask_qty;
    logic        valid_book;
    logic        book_crossed;
    logic [15:0] drop_cnt;

    book_top_builder #(.DEPTH(DEPTH), .PRICE_W(32), .QTY_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_side     (upd_side),
        .upd_price    (upd_price),
        .upd_qty      (upd_qty),
        .upd_clear    (upd_clear),
        .best_bid_px  (best_bid_px),
        .best_bid_qty (best_bid_qty),
        .best_ask_px  (best_ask_px),
        .best_ask_qty (best_ask_qty),
        .valid_book   (valid_book),
        .book_crossed (book_crossed),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] px;
        logic [63:0] qty;
    } lvl_t;

    typedef struct {
        logic [31:0] bbp;
        logic [63:0] bbq;
        logic [31:0] bap;
        logic [63:0] baq;
        logic        vb;
        logic        cr;
        logic [15:0] drop;
    } exp_t;

    lvl_t bid_q[$];
    lvl_t ask_q[$];
    exp_t exp_q[$];
    int   model_drop = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    // Reference book: sorted queues, bids best-first by highest price,
    // asks best-first by lowest price. Pushes the expected EMIT.
    task automatic model_apply(input logic side, input logic [31:0] price,
                               input logic [63:0] qty, input logic clr);
        lvl_t q[$];
        lvl_t n;
        exp_t e;
        int   idx;
        int   pos;
        if (clr) begin
            bid_q.delete();
            ask_q.delete();
        end else begin
            q = side ? ask_q : bid_q;
            idx = -1;
            for (int k = 0; k < q.size(); k++)
                if (idx < 0 && q[k].px == price) idx = k;
            if (idx >= 0) begin
                if (qty != 0) q[idx].qty = qty;
                else q.delete(idx);
            end else if (qty != 0) begin
                pos = -1;
                for (int k = 0; k < q.size(); k++)
                    if (pos < 0 && (side ? (price < q[k].px) : (price > q[k].px))) pos = k;
                n.px  = price;
                n.qty = qty;
                if (pos >= 0) begin
                    q.insert(pos, n);
                    if (q.size() > DEPTH) void'(q.pop_back());
                end else if (q.size() < DEPTH) begin
                    q.push_back(n);
                end else if (model_drop < 65535) begin
                    model_drop++;
                end
            end
            if (side) ask_q = q;
            else bid_q = q;
        end
        e.bbp  = (bid_q.size() > 0) ? bid_q[0].px  : 32'd0;
        e.bbq  = (bid_q.size() > 0) ? bid_q[0].qty : 64'd0;
        e.bap  = (ask_q.size() > 0) ? ask_q[0].px  : 32'd0;
        e.baq  = (ask_q.size() > 0) ? ask_q[0].qty : 64'd0;
        e.vb   = (bid_q.size() > 0) && (ask_q.size() > 0);
        e.cr   = e.vb && (bid_q[0].px >= ask_q[0].px);
        e.drop = model_drop[15:0];
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        bid_q.delete();
        ask_q.delete();
        exp_q.delete();
        model_drop = 0;
    endtask

    // Scoreboard stage: pops the oldest expectation and compares it with
    // the freshly published top-of-book.
    task automatic score_emit(input string tag);
        exp_t e;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s scoreboard: got an EMIT, expected queue empty", tag);
            return;
        end
        e = exp_q.pop_front();
        tests_run++;
        if (best_bid_px !== e.bbp) begin
            tests_failed++;
            $display("[TB] FAIL %s best_bid_px: got %0d, expected %0d", tag, best_bid_px, e.bbp);
        end
        tests_run++;
        if (best_bid_qty !== e.bbq) begin
            tests_failed++;
            $display("[TB] FAIL %s best_bid_qty: got %0d, expected %0d", tag, best_bid_qty, e.bbq);
        end
        tests_run++;
        if (best_ask_px !== e.bap) begin
            tests_failed++;
            $display("[TB] FAIL %s best_ask_px: got %0d, expected %0d", tag, best_ask_px, e.bap);
        end
        tests_run++;
        if (best_ask_qty !== e.baq) begin
            tests_failed++;
            $display("[TB] FAIL %s best_ask_qty: got %0d, expected %0d", tag, best_ask_qty, e.baq);
        end
        tests_run++;
        if (valid_book !== e.vb) begin
            tests_failed++;
            $display("[TB] FAIL %s valid_book: got %0b, expected %0b", tag, valid_book, e.vb);
        end
        tests_run++;
        if (book_crossed !== e.cr) begin
            tests_failed++;
            $display("[TB] FAIL %s book_crossed: got %0b, expected %0b", tag, book_crossed, e.cr);
        end
        tests_run++;
        if (drop_cnt !== e.drop) begin
            tests_failed++;
            $display("[TB] FAIL %s drop_cnt: got %0d, expected %0d", tag, drop_cnt, e.drop);
        end
    endtask

    // One update through the handshake: wait for ready, transfer, queue the
    // expectation, then wait for the EMIT and score it.
    task automatic do_update(input logic side, input logic [31:0] price,
                             input logic [63:0] qty, input logic clr, input string tag);
        int waitc;
        int lat;
        int early_vb;
        @(negedge clk);
        upd_side  = side;
        upd_price = price;
        upd_qty   = qty;
        upd_clear = clr;
        upd_valid = 1'b1;
        waitc = 0;
        while (upd_ready !== 1'b1 && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        tests_run++;
        if (upd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s accept: got upd_ready=%0b, expected 1", tag, upd_ready);
            upd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_apply(side, price, qty, clr);
        #1;
        upd_valid = 1'b0;
        upd_price = 32'hDEAD_BEEF;
        upd_qty   = 64'd12345;
        lat = 0;
        early_vb = 0;
        do begin
            @(negedge clk);
            lat++;
            if (upd_ready !== 1'b1 && valid_book !== 1'b0) early_vb++;
        end while (upd_ready !== 1'b1 && lat < 8);
        tests_run++;
        if (lat !== 3 || early_vb !== 0) begin
            tests_failed++;
            $display("[TB] FAIL %s emit_latency: got %0d cycles (%0d early strobes), expected 3 (0)",
                     tag, lat, early_vb);
        end
        score_emit(tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        upd_valid = 1'b0;
        upd_side = 1'b0;
        upd_price = '0;
        upd_qty = '0;
        upd_clear = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (upd_ready !== 1'b0 || valid_book !== 1'b0 || book_crossed !== 1'b0 || drop_cnt !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got ready=%0b vb=%0b cr=%0b drop=%0d, expected 0 0 0 0",
                     upd_ready, valid_book, book_crossed, drop_cnt);
        end
        tests_run++;
        if (best_bid_px !== 0 || best_bid_qty !== 0 || best_ask_px !== 0 || best_ask_qty !== 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_best: got %0d/%0d %0d/%0d, expected all 0",
                     best_bid_px, best_bid_qty, best_ask_px, best_ask_qty);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (upd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_release_ready: got %0b, expected 1", upd_ready);
        end
        model_reset();
    endtask

    task automatic test_basic();
        do_update(1'b0, 32'd100, 64'd10, 1'b0, "bid100");
        do_update(1'b1, 32'd101, 64'd30, 1'b0, "ask101");
        @(negedge clk);
        tests_run++;
        if (valid_book !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL vb_single_pulse: got %0b, expected 0", valid_book);
        end
    endtask

    task automatic test_modify();
        do_update(1'b0, 32'd102, 64'd5, 1'b0, "bid102_add");
        do_update(1'b0, 32'd102, 64'd0, 1'b0, "bid102_del");
        do_update(1'b0, 32'd97,  64'd0, 1'b0, "bid97_absent");
    endtask

    task automatic test_full();
        do_update(1'b0, 32'd101, 64'd1, 1'b0, "fill101");
        do_update(1'b0, 32'd102, 64'd2, 1'b0, "fill102");
        do_update(1'b0, 32'd103, 64'd3, 1'b0, "fill103");
        do_update(1'b0, 32'd99,  64'd7, 1'b0, "full_drop99");
        tests_run++;
        if (drop_cnt !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL drop_after_99: got %0d, expected 1", drop_cnt);
        end
        do_update(1'b0, 32'd104, 64'd1, 1'b0, "full_evict104");
        do_update(1'b0, 32'd100, 64'd0, 1'b0, "evicted100_del");
        do_update(1'b0, 32'd104, 64'd0, 1'b0, "del104");
        do_update(1'b0, 32'd103, 64'd0, 1'b0, "del103");
        do_update(1'b0, 32'd102, 64'd0, 1'b0, "del102");
        do_update(1'b0, 32'd101, 64'd0, 1'b0, "del101");
    endtask

    task automatic test_crossed();
        do_update(1'b1, 32'd101, 64'd30, 1'b0, "cross_ask101");
        do_update(1'b0, 32'd105, 64'd2,  1'b0, "cross_bid105");
        do_update(1'b1, 32'd7,   64'd9,  1'b1, "clear");
    endtask

    task automatic test_back_to_back();
        logic        sides [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] pxs   [6] = '{32'd90, 32'd95, 32'd91, 32'd94, 32'd90, 32'd96};
        logic [63:0] qtys  [6] = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd0, 64'd5};
        int waitc;
        @(negedge clk);
        upd_side  = sides[0];
        upd_price = pxs[0];
        upd_qty   = qtys[0];
        upd_clear = 1'b0;
        upd_valid = 1'b1;
        waitc = 0;
        while (upd_ready !== 1'b1 && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            model_apply(sides[k], pxs[k], qtys[k], 1'b0);
            @(negedge clk);
            tests_run++;
            if (upd_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL b2b_apply_ready[%0d]: got %0b, expected 0", k, upd_ready);
            end
            upd_price = $urandom;
            upd_qty   = {32'd0, $urandom};
            upd_side  = ~sides[k];
            @(negedge clk);
            tests_run++;
            if (upd_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL b2b_emit_ready[%0d]: got %0b, expected 0", k, upd_ready);
            end
            @(negedge clk);
            tests_run++;
            if (upd_ready !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL b2b_idle_ready[%0d]: got %0b, expected 1", k, upd_ready);
            end
            score_emit($sformatf("b2b%0d", k));
            if (k < 5) begin
                upd_side  = sides[k+1];
                upd_price = pxs[k+1];
                upd_qty   = qtys[k+1];
            end else begin
                upd_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (upd_ready !== 1'b0 || valid_book !== 1'b0 || drop_cnt !== 16'd0 ||
            best_bid_px !== 0 || best_ask_px !== 0 || best_bid_qty !== 0 || best_ask_qty !== 0) begin
            tests_failed++;
            $display("[TB] FAIL midrun_reset: got ready=%0b vb=%0b drop=%0d bid=%0d ask=%0d, expected all 0",
                     upd_ready, valid_book, drop_cnt, best_bid_px, best_ask_px);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (upd_ready !== 1'b1 || drop_cnt !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL midrun_release: got ready=%0b drop=%0d, expected 1 0", upd_ready, drop_cnt);
        end
        model_reset();
        do_update(1'b0, 32'd50, 64'd6, 1'b0, "after_midrun_bid");
        do_update(1'b1, 32'd55, 64'd8, 1'b0, "after_midrun_ask");
    endtask

    task automatic test_reset_in_flight();
        int pulses;
        int waitc;
        @(negedge clk);
        upd_side  = 1'b0;
        upd_price = 32'd120;
        upd_qty   = 64'd9;
        upd_clear = 1'b0;
        upd_valid = 1'b1;
        waitc = 0;
        while (upd_ready !== 1'b1 && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (upd_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL inflight_ready_in_reset: got %0b, expected 0", upd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid_book !== 1'b0) pulses++;
        end
        tests_run++;
        if (pulses !== 0 || best_bid_px !== 0 || best_ask_px !== 0) begin
            tests_failed++;
            $display("[TB] FAIL inflight_no_pulse: got %0d pulses bid=%0d ask=%0d, expected 0 0 0",
                     pulses, best_bid_px, best_ask_px);
        end
        do_update(1'b1, 32'd130, 64'd4, 1'b0, "inflight_post_ask");
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_modify();
        test_full();
        test_crossed();
        test_back_to_back();
        test_reset_midrun();
        test_reset_in_flight();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
